pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core. It sequences the PC register, the IF/ID register and the bubble input of the ID/EX register. It handles three cases: load-use hazards, taken-branch flushes resolved in EX, and a multi-cycle mul/div unit with a start/done handshake. It also keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage core. Drives the PC write
// enable, the IF/ID enable/flush and the ID/EX bubble input. It resolves
// load-use hazards, taken-branch flushes from EX and the start/done
// handshake of the multi-cycle mul/div unit (with a timeout abort). It also
// keeps saturating counters of stall and flush cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   id_*                  ID-stage instruction info (valid, sources, mul/div)
//   ex_*                  EX-stage instruction info (valid, rd, load, taken)
//   md_done               mul/div result ready (1-cycle pulse)
//   md_start              1-cycle start pulse to the mul/div unit
//   pc_en, if_id_en       PC and IF/ID write enables
//   if_id_flush           IF/ID loads a NOP
//   id_ex_bubble          ID/EX loads a zero control word
//   md_error              sticky mul/div timeout flag
//   stall_cnt, flush_cnt  saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_md,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  md_done,
  output logic                  md_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  md_error,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int TMO_W = $clog2(MD_TIMEOUT);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MD_BUSY  = 2'd1;
  localparam logic [1:0] ST_MD_DRAIN = 2'd2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [TMO_W-1:0]      TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [TMO_W-1:0] tmo_r;
  logic [TMO_W-1:0] tmo_nxt_s;
  logic             tmo_hit_s;
  logic             md_error_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             lu_s;
  logic             pc_en_s;
  logic             if_id_en_s;
  logic             if_id_flush_s;
  logic             id_ex_bubble_s;
  logic             md_start_s;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  // x0 is never a real dependency.
  always_comb begin
    lu_s = 1'b0;
    if (ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && id_valid) begin
      lu_s = (id_use_rs1 && (id_rs1 == ex_rd)) ||
             (id_use_rs2 && (id_rs2 == ex_rd));
    end else begin
      lu_s = 1'b0;
    end
  end

  // Control outputs and next state from the registered state and live inputs.
  always_comb begin
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b1;
    md_start_s     = 1'b0;
    state_nxt_s    = state_r;
    tmo_nxt_s      = tmo_r;
    tmo_hit_s      = 1'b0;
    if (rst) begin
      state_nxt_s = ST_RUN;
      tmo_nxt_s   = TMO_ZERO;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ex_branch_taken) begin
            // The flush kills whatever sits in ID, so lu and md are moot.
            pc_en_s        = 1'b1;
            if_id_en_s     = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
          end else if (lu_s) begin
            // One stall cycle: next cycle EX holds the bubble and lu clears.
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
          end else if (id_valid && id_is_md) begin
            md_start_s     = 1'b1;
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            id_ex_bubble_s = 1'b1;
            tmo_nxt_s      = TMO_ZERO;
            state_nxt_s    = ST_MD_BUSY;
          end else begin
            pc_en_s        = 1'b1;
            if_id_en_s     = 1'b1;
            id_ex_bubble_s = 1'b0;
          end
        end
        ST_MD_BUSY: begin
          // EX holds only bubbles here, so a taken branch cannot occur.
          tmo_nxt_s = tmo_r + TMO_ONE;
          if (md_done) begin
            state_nxt_s = ST_MD_DRAIN;
          end else if (tmo_r == TMO_LAST) begin
            tmo_hit_s   = 1'b1;
            state_nxt_s = ST_MD_DRAIN;
          end else begin
            state_nxt_s = ST_MD_BUSY;
          end
        end
        ST_MD_DRAIN: begin
          // Let the mul/div instruction advance without looking at id_is_md,
          // otherwise it would re-trigger the unit.
          pc_en_s    = 1'b1;
          if_id_en_s = 1'b1;
          if (ex_branch_taken) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
          end else begin
            id_ex_bubble_s = 1'b0;
          end
          state_nxt_s = ST_RUN;
        end
        default: begin
          state_nxt_s = ST_RUN;
          tmo_nxt_s   = TMO_ZERO;
        end
      endcase
    end
  end

  // State, timeout counter, sticky error flag and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      tmo_r       <= TMO_ZERO;
      md_error_r  <= 1'b0;
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      tmo_r   <= tmo_nxt_s;
      if (tmo_hit_s) begin
        md_error_r <= 1'b1;
      end
      if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (if_id_flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign md_start     = md_start_s;
  assign pc_en        = pc_en_s;
  assign if_id_en     = if_id_en_s;
  assign if_id_flush  = if_id_flush_s;
  assign id_ex_bubble = id_ex_bubble_s;
  assign md_error     = md_error_r;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MD_TIMEOUT=8, CNT_W=4).
// Each cycle's expected control word and counter values are pushed to a
// scoreboard queue as stimulus is applied, then popped and compared.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  // {md_start, pc_en, if_id_en, if_id_flush, id_ex_bubble}
  localparam logic [4:0] C_RUN   = 5'b01100;
  localparam logic [4:0] C_STALL = 5'b00001;
  localparam logic [4:0] C_FLUSH = 5'b01111;
  localparam logic [4:0] C_START = 5'b10001;

  typedef struct {
    string         tag;
    logic [4:0]    ctrl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs1, id_use_rs2, id_is_md;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          ex_valid, ex_mem_read, ex_branch_taken, md_done;
  logic          md_start, pc_en, if_id_en, if_id_flush, id_ex_bubble, md_error;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t          sb[$];
  int            n_eval = 0;
  int            n_fail = 0;
  logic          err_exp = 1'b0;
  logic [CW-1:0] stall_exp = 4'd0;
  logic [CW-1:0] flush_exp = 4'd0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MD_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_md(id_is_md),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .md_done(md_done),
    .md_start(md_start), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .md_error(md_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic clr();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_md = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; md_done = 1'b0;
  endtask

  // Load in EX writing rd, ID reads rs1 (hazard when rd == rs1 and rd != 0).
  task automatic set_lu(input logic [RW-1:0] rd, input logic [RW-1:0] rs1);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = rs1;
  endtask

  // Called just after a negedge with inputs applied; returns after next negedge.
  task automatic cyc(input string tag, input logic [4:0] ec);
    exp_t       e;
    exp_t       p;
    logic [4:0] obs;
    e.tag = tag; e.ctrl = ec; e.err = err_exp; e.stall = stall_exp; e.flush = flush_exp;
    sb.push_back(e);
    #1;
    p   = sb.pop_front();
    obs = {md_start, pc_en, if_id_en, if_id_flush, id_ex_bubble};
    n_eval++;
    assert (obs === p.ctrl) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", p.tag, obs, p.ctrl);
    end
    n_eval++;
    assert (md_error === p.err) else begin
      n_fail++;
      $error("FAIL %s md_error: observed %b expected %b", p.tag, md_error, p.err);
    end
    n_eval++;
    assert (stall_cnt === p.stall) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", p.tag, stall_cnt, p.stall);
    end
    n_eval++;
    assert (flush_cnt === p.flush) else begin
      n_fail++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", p.tag, flush_cnt, p.flush);
    end
    @(posedge clk);
    if (rst) begin
      stall_exp = 4'd0; flush_exp = 4'd0; err_exp = 1'b0;
    end else begin
      if (!ec[3] && stall_exp != 4'd15) stall_exp = stall_exp + 4'd1;
      if (ec[1] && flush_exp != 4'd15) flush_exp = flush_exp + 4'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc("reset", C_STALL);
    rst = 1'b0;
    cyc("idle", C_RUN);

    // Load-use on rs1: one stall, then the bubble in EX clears the hazard.
    set_lu(5'd5, 5'd5);
    cyc("lu_rs1", C_STALL);
    ex_valid = 1'b0;
    cyc("lu_bubble", C_RUN);
    set_lu(5'd0, 5'd0);
    cyc("lu_rd0", C_RUN);
    set_lu(5'd5, 5'd5); id_use_rs1 = 1'b0;
    cyc("lu_no_use", C_RUN);
    clr();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd9;
    cyc("lu_rs2", C_STALL);
    ex_valid = 1'b0;
    cyc("lu_rs2_bubble", C_RUN);

    // Taken branch wins over a simultaneous load-use hazard.
    clr(); set_lu(5'd5, 5'd5); ex_branch_taken = 1'b1;
    cyc("br_over_lu", C_FLUSH);
    clr();
    cyc("after_br", C_RUN);
    md_done = 1'b1;
    cyc("stray_done", C_RUN);
    clr();
    cyc("stray_done_run", C_RUN);

    // Mul/div with md_done 4 cycles after start; branch in BUSY is ignored.
    id_valid = 1'b1; id_is_md = 1'b1;
    cyc("md_start", C_START);
    cyc("md_busy1", C_STALL);
    ex_branch_taken = 1'b1;
    cyc("md_busy_br", C_STALL);
    ex_branch_taken = 1'b0;
    cyc("md_busy3", C_STALL);
    md_done = 1'b1;
    cyc("md_busy_done", C_STALL);
    md_done = 1'b0;
    cyc("md_drain", C_RUN);
    clr();
    cyc("md_run", C_RUN);

    // Timeout: md_done never arrives, abort after 8 cycles in BUSY.
    id_valid = 1'b1; id_is_md = 1'b1;
    cyc("to_start", C_START);
    for (int i = 0; i < 8; i++) cyc("to_busy", C_STALL);
    err_exp = 1'b1;
    cyc("to_drain", C_RUN);
    clr();
    cyc("to_run", C_RUN);
    set_lu(5'd3, 5'd3);
    cyc("to_lu", C_STALL);
    ex_valid = 1'b0;
    cyc("to_sticky", C_RUN);

    // Saturation: many load-use stalls pin stall_cnt at 15.
    for (int i = 0; i < 20; i++) begin
      set_lu(5'd7, 5'd7);
      cyc("sat_lu", C_STALL);
      ex_valid = 1'b0;
      cyc("sat_bubble", C_RUN);
    end

    // Reset in MD_BUSY, then a late md_done that must be ignored.
    clr(); id_valid = 1'b1; id_is_md = 1'b1;
    cyc("rb_start", C_START);
    cyc("rb_busy1", C_STALL);
    cyc("rb_busy2", C_STALL);
    rst = 1'b1;
    cyc("rb_reset", C_STALL);
    rst = 1'b0; clr(); md_done = 1'b1;
    cyc("rb_late_done", C_RUN);
    md_done = 1'b0;
    cyc("rb_run", C_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
